my_ram8_clr: RTL and testbench

MY_RAM8_CLR -- requirements
Module: my_ram8_clr

---
 rtl/my_ram8_clr.sv | 46 ++++
 tb/tb_my_ram8_clr.sv | 112 +++++++++++
 2 files changed

// File: rtl/my_ram8_clr.sv
// my_ram8_clr: 8x16 register RAM with a sequential clear engine and nonzero status flags
module my_ram8_clr (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic [2:0]  address,
  input  logic        load,
  input  logic        clear_start,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  nonzero,
  output logic        any_nonzero,
  output logic        all_nonzero
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t      state;
  logic [2:0]  cnt;
  logic [15:0] word [8];
  logic [7:0]  we;
  assign we = (state != CLEAR && load) ? 8'(8'h01 << address) : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) word[i] <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (we[i]) word[i] <= in;
        else if (state == CLEAR && cnt == 3'(i)) word[i] <= '0;
      if (state == CLEAR) begin
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) state <= DONE;
      end else if (clear_start) begin
        state <= CLEAR;
        cnt   <= '0;
      end else state <= IDLE;
    end
  end
  assign out  = word[address];
  assign busy = state == CLEAR;
  assign done = state == DONE;
  for (genvar k = 0; k < 8; k++) assign nonzero[k] = |word[k];
  assign any_nonzero = |nonzero;
  assign all_nonzero = &nonzero;
endmodule

// File: tb/tb_my_ram8_clr.sv
// tb_my_ram8_clr: directed vector table plus hand sequences for my_ram8_clr
module tb_my_ram8_clr;
  logic        clk = 0, reset = 0, load = 0, clear_start = 0;
  logic [15:0] in = 0;
  logic [2:0]  address = 0;
  logic [15:0] out;
  logic        busy, done, any_nonzero, all_nonzero;
  logic [7:0]  nonzero;
  int checks = 0, passes = 0;

  my_ram8_clr dut (
    .clk(clk), .reset(reset), .in(in), .address(address), .load(load),
    .clear_start(clear_start), .out(out), .busy(busy), .done(done),
    .nonzero(nonzero), .any_nonzero(any_nonzero), .all_nonzero(all_nonzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, ld, cs;
    logic [2:0] a;
    logic [15:0] d, o;
    logic b, dn;
    logic [7:0] nz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, ld, cs, input logic [2:0] a,
                              input logic [15:0] d, o, input logic b, dn,
                              input logic [7:0] nz);
    vec_t v;
    v.rst = rst; v.ld = ld; v.cs = cs; v.a = a; v.d = d;
    v.o = o; v.b = b; v.dn = dn; v.nz = nz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst; load = v.ld; clear_start = v.cs; address = v.a; in = v.d;
    @(posedge clk);
    #1;
    chk({nm, ".out"}, out, v.o);
    chk({nm, ".busy"}, 16'(busy), 16'(v.b));
    chk({nm, ".done"}, 16'(done), 16'(v.dn));
    chk({nm, ".nonzero"}, 16'(nonzero), 16'(v.nz));
    chk({nm, ".any"}, 16'(any_nonzero), 16'(|v.nz));
    chk({nm, ".all"}, 16'(all_nonzero), 16'(&v.nz));
  endtask

  initial begin
    logic [7:0] acc;
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 3, 16'hBEEF, 16'hBEEF, 0, 0, 8'h08));
    acc = 8'h08;
    for (int k = 0; k < 8; k++) begin
      acc = acc | 8'(8'h01 << k);
      tbl.push_back(mk(0, 1, 0, 3'(k), 16'(k + 1), 16'(k + 1), 0, 0, acc));
    end
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, 0, 3'(k), 0, 16'(k + 1), 0, 0, 8'hFF));
    tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0001, 1, 0, 8'hFF));
    for (int j = 0; j < 8; j++)
      tbl.push_back(mk(0, 0, 0, 3'(j), 0, 0, j < 7, j == 7, 8'(8'hFF << (j + 1))));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // load and restart requests are ignored while clearing
    apply(mk(0, 1, 0, 5, 16'hAAAA, 16'hAAAA, 0, 0, 8'h20), "ign_load");
    apply(mk(0, 0, 1, 5, 0, 16'hAAAA, 1, 0, 8'h20), "ign_start");
    for (int e = 1; e <= 5; e++)
      apply(mk(0, 1, 1, 5, 16'hFFFF, 16'hAAAA, 1, 0, 8'h20), $sformatf("ign_e%0d", e));
    apply(mk(0, 1, 1, 5, 16'hFFFF, 0, 1, 0, 8'h00), "ign_e6");
    apply(mk(0, 1, 1, 5, 16'hFFFF, 0, 1, 0, 8'h00), "ign_e7");
    apply(mk(0, 1, 1, 5, 16'hFFFF, 0, 0, 1, 8'h00), "ign_e8");
    apply(mk(0, 0, 0, 5, 0, 0, 0, 0, 8'h00), "ign_idle");

    // simultaneous load and clear_start; then DONE straight back into CLEAR
    apply(mk(0, 1, 1, 2, 16'h1234, 16'h1234, 1, 0, 8'h04), "both_e0");
    apply(mk(0, 0, 0, 2, 0, 16'h1234, 1, 0, 8'h04), "both_e1");
    apply(mk(0, 0, 0, 2, 0, 16'h1234, 1, 0, 8'h04), "both_e2");
    apply(mk(0, 0, 0, 2, 0, 0, 1, 0, 8'h00), "both_e3");
    for (int e = 4; e <= 7; e++) apply(mk(0, 0, 0, 2, 0, 0, 1, 0, 8'h00), $sformatf("both_e%0d", e));
    apply(mk(0, 0, 0, 2, 0, 0, 0, 1, 8'h00), "both_e8");
    apply(mk(0, 0, 1, 2, 0, 0, 1, 0, 8'h00), "done_restart");
    for (int e = 1; e <= 7; e++) apply(mk(0, 0, 0, 2, 0, 0, 1, 0, 8'h00), $sformatf("re_e%0d", e));
    apply(mk(0, 0, 0, 2, 0, 0, 0, 1, 8'h00), "re_e8");
    apply(mk(0, 0, 0, 2, 0, 0, 0, 0, 8'h00), "re_idle");

    // reset aborts a running clear
    apply(mk(0, 1, 0, 7, 16'h7777, 16'h7777, 0, 0, 8'h80), "ab_w7");
    apply(mk(0, 1, 0, 0, 16'h0F0F, 16'h0F0F, 0, 0, 8'h81), "ab_w0");
    apply(mk(0, 0, 1, 7, 0, 16'h7777, 1, 0, 8'h81), "ab_start");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h80), "ab_e1");
    apply(mk(0, 0, 0, 7, 0, 16'h7777, 1, 0, 8'h80), "ab_e2");
    apply(mk(0, 0, 0, 7, 0, 16'h7777, 1, 0, 8'h80), "ab_e3");
    apply(mk(1, 0, 0, 7, 0, 0, 0, 0, 8'h00), "ab_reset");
    apply(mk(0, 0, 0, 7, 0, 0, 0, 0, 8'h00), "ab_idle");
    apply(mk(0, 0, 1, 7, 0, 0, 1, 0, 8'h00), "ab_restart");
    for (int e = 1; e <= 7; e++) apply(mk(0, 0, 0, 7, 0, 0, 1, 0, 8'h00), $sformatf("ab_re%0d", e));
    apply(mk(0, 0, 0, 7, 0, 0, 0, 1, 8'h00), "ab_re8");
    apply(mk(0, 0, 0, 7, 0, 0, 0, 0, 8'h00), "ab_end");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
